program_loader: RTL and testbench

Writer-side counterpart to the CPU core's instruction fetch path. Receives a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into the instruction memory the core fetches from. It holds the core in reset for the whole load and releases it only after a complete, valid frame.

---
 rtl/program_loader.sv | 169 ++++++++++++++++
 tb/tb_program_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: turns a framed big-endian byte stream into 16-bit instruction memory writes, holding the core in reset until a clean load.
// Define LOADER_CHECKSUM_EN for a trailing sum-of-words CSUM field; each write costs a one-cycle in_ready bubble.
module program_loader #(
  parameter int PC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                imem_we,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [15:0]         imem_wdata,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE
  } state_t;

  localparam logic [PC_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [15:0]         CAPACITY = 16'(1 << PC_WIDTH);

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         sum_q, sum_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                active;
  logic                xfer;
  logic [15:0]         word;
  logic                fin;
  logic                bad;

  assign active   = (state_q != IDLE) && (state_q != DONE);
  assign in_ready = active && !we_q;
  assign xfer     = in_valid && in_ready;
  assign word     = {hi_q, in_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    done_d  = done_q;
    error_d = error_q;
    fin     = 1'b0;
    bad     = 1'b0;

    // Address advances after the write cycle; once the last slot is used it parks and further words are dropped.
    if (we_q) begin
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + PC_WIDTH'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN_HI;
          addr_d  = '0;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
          sum_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      LEN_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        cnt_d   = (word == 16'd0) ? CAPACITY : word;
        state_d = DATA_HI;
      end
      DATA_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (xfer) begin
        we_d  = !full_q;
        sum_d = sum_q + word;
        cnt_d = cnt_q - 16'd1;
        if (full_q) ovf_d   = 1'b1;
        else        wdata_d = word;
        if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM_HI;
`else
          state_d = DONE;
          fin     = 1'b1;
`endif
        end else begin
          state_d = DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = CSUM_LO;
      end
      CSUM_LO: if (xfer) begin
        bad     = (word != sum_q);
        state_d = DONE;
        fin     = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (fin) begin
      error_d = ovf_d | bad;
      done_d  = !(ovf_d | bad);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = active;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = !((state_q == DONE) && !error_q);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader at PC_WIDTH=2; expected writes are queued as frames are built.
module tb_program_loader;
  localparam int PCW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic           imem_we;
  logic [PCW-1:0] imem_addr;
  logic [15:0]    imem_wdata;
  logic           cpu_hold;
  logic           busy;
  logic           done;
  logic           error;

  program_loader #(.PC_WIDTH(PCW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;

  logic [PCW+15:0] exp_q[$];
  logic [PCW+15:0] exp_e;
  byte unsigned    bq[$];
  logic [15:0]     words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  always @(negedge clock) begin
    if (imem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(imem_we), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(exp_e[PCW+15:16]));
        check("wr_data", 32'(imem_wdata), 32'(exp_e[15:0]));
      end
    end
  end

  // Frame from the words queue; only the first 2^PCW words are expected to land in memory.
  task automatic build(input logic [15:0] len);
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
    sum = 16'd0;
`endif
    bq.delete();
    bq.push_back(len[15:8]);
    bq.push_back(len[7:0]);
    foreach (words[i]) begin
      bq.push_back(words[i][15:8]);
      bq.push_back(words[i][7:0]);
`ifdef LOADER_CHECKSUM_EN
      sum = sum + words[i];
`endif
      if (i < (1 << PCW)) exp_q.push_back({PCW'(i), words[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(sum[15:8]);
    bq.push_back(sum[7:0]);
`endif
  endtask

  task automatic do_start();
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_rdy",  32'(in_ready), 32'd1);
    check("start_busy", 32'(busy),     32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done),     32'd0);
  endtask

  task automatic send(input bit toggle, input int start_at);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < bq.size() && cyc < 500) begin
      @(negedge clock);
      start    = (cyc == start_at);
      in_valid = toggle ? (cyc[0] == 1'b0) : 1'b1;
      in_data  = bq[idx];
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
    check("send_bytes", idx, bq.size());
  endtask

  task automatic finish_check(input int nwr, input bit exp_err);
    #1;
    check("wr_count",  wr_cnt,          nwr);
    check("queue_left", exp_q.size(),   0);
    check("done",      32'(done),       32'(!exp_err));
    check("error",     32'(error),      32'(exp_err));
    check("cpu_hold",  32'(cpu_hold),   32'(exp_err));
    check("busy_end",  32'(busy),       32'd0);
    check("rdy_end",   32'(in_ready),   32'd0);
    wr_cnt = 0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_rdy",   32'(in_ready),   32'd0);
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  32'(imem_addr),  32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    check("rst_hold",  32'(cpu_hold),   32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    reset = 1'b0;

    // Bytes offered while idle must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (2) @(negedge clock);
    check("idle_rdy", 32'(in_ready), 32'd0);

    words = '{16'h1234, 16'hABCD};
    do_start();
    build(16'd2);
    send(1'b0, -1);
    finish_check(2, 1'b0);

    // Reload from DONE with throttled input.
    do_start();
    build(16'd2);
    send(1'b1, -1);
    finish_check(2, 1'b0);

    // LEN=0 means full capacity; a mid-load start must be ignored.
    words = '{16'h0101, 16'h2202, 16'h3303, 16'hF00F};
    do_start();
    build(16'd0);
    send(1'b0, 5);
    finish_check(4, 1'b0);

    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_start();
    build(16'd5);
    send(1'b0, -1);
    finish_check(4, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    do_start();
    bq = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
    exp_q.push_back({PCW'(0), 16'h0005});
    send(1'b0, -1);
    finish_check(1, 1'b1);
`endif

    // Reset after the high byte of the second word.
    do_start();
    bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    exp_q.push_back({PCW'(0), 16'h1234});
    send(1'b0, -1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_rdy",  32'(in_ready), 32'd0);
    check("mrst_hold", 32'(cpu_hold), 32'd1);
    check("mrst_busy", 32'(busy),     32'd0);
    check("mrst_we",   32'(imem_we),  32'd0);
    repeat (3) @(negedge clock);
    #1;
    check("mrst_wr",   wr_cnt,        1);
    check("mrst_q",    exp_q.size(),  0);
    wr_cnt = 0;

    words = '{16'hC0DE};
    do_start();
    build(16'd1);
    send(1'b0, -1);
    finish_check(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
